program_loader: RTL and testbench

- Loads a program into the computer's instruction memory from a byte stream over a valid/ready handshake. This is the hardware path that replaces loading the memory from a file at simulation start.
- Holds the CPU in reset while loading, writes one 15-bit instruction word per two bytes, verifies an XOR checksum, then releases the CPU.
- Sits between an external byte source (UART receiver or bench) and the instruction memory write port.

---
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Loads instruction memory from a byte stream (count, HI/LO word pairs, XOR checksum); holds CPU in reset meanwhile.
// Latency: one im_we pulse registered one cycle after each LO byte; done/error one cycle after the final byte.
// Backpressure: in_ready is high in every loading state; the source may stall indefinitely, and bytes may arrive every cycle.
module program_loader #(
   parameter int IM_ADDR_W = 8,
   parameter int IM_DATA_W = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 im_we,
   output logic [IM_ADDR_W-1:0] im_addr,
   output logic [IM_DATA_W-1:0] im_data,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error,
   output logic [IM_ADDR_W:0]   words_loaded
);

   // Compare width covers both the 8-bit count byte and the full-depth count.
   localparam int CW = (IM_ADDR_W + 1 > 9) ? IM_ADDR_W + 1 : 9;
   localparam logic [CW-1:0] FULL_DEPTH = CW'(1) << IM_ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_HI,
      S_LO,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t               state;
   logic [7:0]           count_q;
   logic [7:0]           hi_q;
   logic [7:0]           csum_q;
   logic [IM_ADDR_W-1:0] addr_q;
   logic [CW-1:0]        target;
   logic [CW-1:0]        next_count;
   logic                 accept;

   assign in_ready   = (state == S_COUNT) || (state == S_HI) ||
                       (state == S_LO)    || (state == S_CHECK);
   assign accept     = in_valid && in_ready;
   assign target     = (count_q == 8'd0) ? FULL_DEPTH : CW'(count_q);
   assign next_count = CW'(words_loaded) + CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         count_q      <= '0;
         hi_q         <= '0;
         csum_q       <= '0;
         addr_q       <= '0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_data      <= '0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         im_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state        <= S_COUNT;
                  cpu_hold     <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  csum_q       <= '0;
                  addr_q       <= '0;
               end
            end
            S_COUNT: begin
               if (accept) begin
                  count_q <= in_data;
                  state   <= S_HI;
               end
            end
            S_HI: begin
               if (accept) begin
                  if (in_data[7]) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else begin
                     hi_q   <= in_data;
                     csum_q <= csum_q ^ in_data;
                     state  <= S_LO;
                  end
               end
            end
            S_LO: begin
               if (accept) begin
                  csum_q       <= csum_q ^ in_data;
                  im_we        <= 1'b1;
                  im_addr      <= addr_q;
                  im_data      <= IM_DATA_W'({hi_q[6:0], in_data});
                  addr_q       <= addr_q + 1'b1;
                  words_loaded <= words_loaded + 1'b1;
                  state        <= (next_count == target) ? S_CHECK : S_HI;
               end
            end
            S_CHECK: begin
               if (accept) begin
                  if (in_data == csum_q) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader (4-bit address variant so full-depth loads stay short).
// Expected writes and checksums come from a word-list model; all checks go through chk().
module tb_program_loader;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [14:0]   im_data;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   program_loader #(.IM_ADDR_W(AW), .IM_DATA_W(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_data      (im_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         hold_bad = 0;
   int         wr_addr[$];
   int         wr_data[$];
   int         exp_words[$];
   logic [7:0] stream[$];

   always @(negedge clk) begin
      if (im_we) begin
         wr_addr.push_back(int'(im_addr));
         wr_data.push_back(int'(im_data));
         if (!cpu_hold) hold_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stream image: count byte, HI/LO per word, XOR of all word bytes (optionally corrupted).
   task automatic build_stream(input int n_field, input bit bad_ck);
      logic [7:0] ck;
      logic [7:0] hi;
      logic [7:0] lo;
      stream.delete();
      stream.push_back(8'(n_field));
      ck = 8'h00;
      foreach (exp_words[i]) begin
         hi = {1'b0, exp_words[i][14:8]};
         lo = exp_words[i][7:0];
         stream.push_back(hi);
         stream.push_back(lo);
         ck = ck ^ hi ^ lo;
      end
      stream.push_back(bad_ck ? (ck ^ 8'h01) : ck);
   endtask

   // Returns at a negedge with the byte presented and in_ready high, so the next posedge accepts it.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
      int t;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         start    = poke_start && ($urandom_range(1) == 1);
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_stream(input int first, input int last, input int gap_max, input bit poke_start);
      for (int i = first; i <= last; i++)
         send_byte(stream[i], (gap_max > 0) ? $urandom_range(gap_max) : 0, poke_start);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      hold_bad = 0;
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_wr_count"}, wr_addr.size(), exp_words.size());
      for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
         chk({tag, "_wr_addr"}, wr_addr[i], i % (1 << AW));
         chk({tag, "_wr_data"}, wr_data[i], exp_words[i]);
      end
      chk({tag, "_hold_during_load"}, hold_bad, 0);
   endtask

   task automatic check_done(input string tag, input int n_words);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_cpu_hold"}, cpu_hold, 0);
      chk({tag, "_words"}, words_loaded, n_words);
   endtask

   task automatic full_load(input string tag, input int n_field, input bit bad_ck,
                            input int gap_max, input bit poke_start);
      clear_log();
      start_pulse();
      build_stream(n_field, bad_ck);
      send_stream(0, stream.size() - 1, gap_max, poke_start);
      check_writes(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_im_we", im_we, 0);
      chk("rst_im_addr", im_addr, 0);
      chk("rst_im_data", im_data, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_words", words_loaded, 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed three-word load
      exp_words = '{15'h0063, 15'h1A32, 15'h7FFF};
      full_load("n3", 3, 1'b0, 0, 1'b0);
      check_done("n3", 3);

      // Start from DONE re-holds the CPU, then a bad checksum aborts
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_cpu_hold", cpu_hold, 1);
      chk("restart_done", done, 0);
      chk("restart_in_ready", in_ready, 1);
      clear_log();
      build_stream(3, 1'b1);
      send_stream(0, stream.size() - 1, 0, 1'b0);
      check_writes("badck");
      chk("badck_error", error, 1);
      chk("badck_done", done, 0);
      chk("badck_cpu_hold", cpu_hold, 1);
      chk("badck_in_ready", in_ready, 0);

      full_load("after_err", 3, 1'b0, 0, 1'b0);
      check_done("after_err", 3);

      // Malformed HI byte
      clear_log();
      start_pulse();
      send_byte(8'd1, 0, 1'b0);
      send_byte(8'h80, 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("badhi_error", error, 1);
      chk("badhi_done", done, 0);
      chk("badhi_cpu_hold", cpu_hold, 1);
      chk("badhi_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      chk("badhi_no_write", wr_addr.size(), 0);

      // Randomized sessions with stalls and ignored mid-session start pulses
      for (int s = 0; s < 6; s++) begin
         n = (s == 0) ? 2 : $urandom_range(1, 8);
         exp_words.delete();
         for (int i = 0; i < n; i++) exp_words.push_back(int'(15'($urandom)));
         full_load("gaps", n, 1'b0, 5, 1'b1);
         check_done("gaps", n);
      end

      // Full depth (count byte 0)
      exp_words.delete();
      for (int i = 0; i < (1 << AW); i++) exp_words.push_back(i * 32'h101);
      full_load("full", 0, 1'b0, 0, 1'b0);
      check_done("full", 1 << AW);

      // Reset after the second word is written
      exp_words.delete();
      for (int i = 0; i < 5; i++) exp_words.push_back(int'(15'($urandom)));
      clear_log();
      start_pulse();
      build_stream(5, 1'b0);
      send_stream(0, 4, 0, 1'b0);
      chk("midrst_writes", wr_addr.size(), 2);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_cpu_hold", cpu_hold, 1);
      chk("midrst_done", done, 0);
      chk("midrst_error", error, 0);
      chk("midrst_words", words_loaded, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_im_we", im_we, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_idle_in_ready", in_ready, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
